// File: rtl/bcd2bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, digit constants and iteration-counter sizing.
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  function automatic int unsigned iter_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ITER_W = iter_width(10);

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction cell: a shifted BCD digit of 8 or more
// had a borrowed 10 folded in as 16, so subtract 3 (16/2 - 10/2).
module bcd_digit_adjust
  import bcd2bin_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd8) o_digit = i_digit - 4'd3;
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock (reverse double-dabble).
// Optional macro BCD2BIN_SATURATE_EN: saturate the result on range errors.
module bcd_to_bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int unsigned NDIG = 3,
  parameter int unsigned W    = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
  input  logic                        neg,
  input  logic                        signed_mode,
  output logic                        busy,
  output logic                        valid,
  output logic [W-1:0]                result,
  output logic                        err
);

  localparam int unsigned BW = BCD_DIGIT_W * NDIG;
  localparam int unsigned CW = iter_width(W);
  localparam logic [W-1:0] NEG_MAG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

  state_t r_state, w_next;

  logic [BW-1:0]   r_bcd;
  logic [W-1:0]    r_bin;
  logic [CW-1:0]   r_iter;
  logic            r_neg;
  logic            r_smode;
  logic            r_digit_err;
  logic            r_valid;
  logic [W-1:0]    r_result;
  logic            r_err;

  logic [BW+W-1:0] w_shift;
  logic [BW-1:0]   w_bcd_sh;
  logic [BW-1:0]   w_bcd_adj;
  logic [W-1:0]    w_bin_sh;
  logic            w_digit_err;
  logic            w_rng_err;
  logic            w_err;
  logic [W-1:0]    w_mag_out;
  logic [W-1:0]    w_res;
`ifdef BCD2BIN_SATURATE_EN
  logic [W-1:0]    w_sat;
`endif

  // Shift then adjust happen in the same cycle.
  assign w_shift  = {r_bcd, r_bin} >> 1;
  assign w_bcd_sh = w_shift[BW+W-1:W];
  assign w_bin_sh = w_shift[W-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (w_bcd_sh [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    w_digit_err = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX) w_digit_err = 1'b1;
    end
  end

  always_comb begin
    w_rng_err = 1'b0;
`ifdef BCD2BIN_SATURATE_EN
    w_sat     = '0;
`endif
    if (!r_smode) begin
      w_rng_err = r_neg;
    end else if (!r_neg) begin
      w_rng_err = (r_bin > POS_MAX);
`ifdef BCD2BIN_SATURATE_EN
      w_sat     = POS_MAX;
`endif
    end else begin
      w_rng_err = (r_bin > NEG_MAG);
`ifdef BCD2BIN_SATURATE_EN
      w_sat     = NEG_MAG;
`endif
    end
    w_err     = r_digit_err | w_rng_err;
    w_mag_out = (r_smode && r_neg) ? (~r_bin + W'(1)) : r_bin;
    w_res     = w_mag_out;
    if (w_err) begin
`ifdef BCD2BIN_SATURATE_EN
      // Digit errors always clear the result; only range errors saturate.
      w_res = r_digit_err ? '0 : w_sat;
`else
      w_res = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = S_SHIFT;
      S_SHIFT:  if (r_iter == CW'(W-1)) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd       <= '0;
      r_bin       <= '0;
      r_iter      <= '0;
      r_neg       <= 1'b0;
      r_smode     <= 1'b0;
      r_digit_err <= 1'b0;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcd   <= bcd_in;
            r_neg   <= neg;
            r_smode <= signed_mode;
          end
        end
        S_LOAD: begin
          r_bin       <= '0;
          r_iter      <= '0;
          r_digit_err <= w_digit_err;
        end
        S_SHIFT: begin
          r_bcd  <= w_bcd_adj;
          r_bin  <= w_bin_sh;
          r_iter <= r_iter + CW'(1);
        end
        S_FINISH: begin
          r_result <= w_res;
          r_err    <= w_err;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign valid  = r_valid;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expectations from a decimal model,
// queued at start and compared when valid pulses.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] bcd_in = '0;
  logic        neg = 1'b0;
  logic        signed_mode = 1'b0;
  logic        busy;
  logic        valid;
  logic [9:0]  result;
  logic        err;

  typedef struct packed {
    logic [9:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  bcd_to_bin_seq #(.NDIG(3), .W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bcd_in      (bcd_in),
    .neg         (neg),
    .signed_mode (signed_mode),
    .busy        (busy),
    .valid       (valid),
    .result      (result),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [11:0] b, input logic n, input logic sm);
    exp_t e;
    int   d2, d1, d0, mag, r;
    logic de, re;
    d2  = int'(b[11:8]);
    d1  = int'(b[7:4]);
    d0  = int'(b[3:0]);
    de  = (d2 > 9) || (d1 > 9) || (d0 > 9);
    mag = d2 * 100 + d1 * 10 + d0;
    if (!sm)     begin re = n;          r = mag; end
    else if (!n) begin re = (mag > 511); r = mag; end
    else         begin re = (mag > 512); r = (1024 - mag) % 1024; end
    e.err = de | re;
    if (e.err) begin
      r = 0;
`ifdef BCD2BIN_SATURATE_EN
      if (!de && re) r = !sm ? 0 : (n ? 512 : 511);
`endif
    end
    e.res = r[9:0];
    return e;
  endfunction

  task automatic drive(input logic [11:0] b, input logic n, input logic sm);
    bcd_in      = b;
    neg         = n;
    signed_mode = sm;
    start       = 1'b1;
    sb.push_back(model(b, n, sm));
  endtask

  task automatic check_out(input string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: valid with empty scoreboard, result=%0d", name, result);
      return;
    end
    e = sb.pop_front();
    if (result !== e.res || err !== e.err) begin
      n_err++;
      $display("FAIL %s: got result=%b err=%b, expected result=%b err=%b",
               name, result, err, e.res, e.err);
    end
  endtask

  // Starts one conversion from an IDLE cycle and checks latency and output.
  task automatic run_one(input logic [11:0] b, input logic n, input logic sm, input string name);
    int got;
    drive(b, n, sm);
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy: got busy=%b, expected 1", name, busy);
    end
    got = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin got = c; break; end
    end
    n_vec++;
    if (got != 12) begin
      n_err++;
      $display("FAIL %s_latency: got valid at cycle %0d, expected 12", name, got);
      if (got == 0) void'(sb.pop_front());
    end
    if (got != 0) begin
      check_out(name);
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s_busy_fall: got busy=%b on valid, expected 0", name, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 10'd0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got busy=%b valid=%b result=%0d err=%b, expected all 0",
               busy, valid, result, err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    run_one(12'h003, 1'b0, 1'b0, "u_003");
    run_one(12'h999, 1'b0, 1'b0, "u_999");
    run_one(12'h000, 1'b0, 1'b0, "u_000");
    run_one(12'h005, 1'b1, 1'b0, "u_neg_err");
    for (int k = 0; k < 4; k++) begin
      logic [11:0] b;
      b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_one(b, 1'b0, 1'b0, "u_rand");
    end
  endtask

  task automatic test_signed;
    run_one(12'h001, 1'b1, 1'b1, "s_neg1");
    run_one(12'h512, 1'b1, 1'b1, "s_neg512");
    run_one(12'h511, 1'b0, 1'b1, "s_pos511");
    run_one(12'h000, 1'b1, 1'b1, "s_negzero");
    run_one(12'h512, 1'b0, 1'b1, "s_pos512_err");
    run_one(12'h513, 1'b1, 1'b1, "s_neg513_err");
    run_one(12'h999, 1'b0, 1'b1, "s_pos999_err");
    run_one(12'h037, 1'b1, 1'b1, "s_neg37");
  endtask

  task automatic test_digit_err;
    run_one(12'h0A5, 1'b0, 1'b1, "d_0A5");
    run_one(12'hF00, 1'b0, 1'b0, "d_F00");
    run_one(12'h00A, 1'b1, 1'b1, "d_00A");
  endtask

  task automatic test_start_ignored;
    int nv, first;
    drive(12'h123, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    nv = 0;
    first = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin bcd_in = 12'h777; neg = 1'b1; signed_mode = 1'b1; start = 1'b1; end
      if (c == 6) start = 1'b0;
      if (valid === 1'b1) begin
        nv++;
        if (nv == 1) begin first = c; check_out("ignored_first"); end
      end
    end
    n_vec++;
    if (nv != 1 || first != 12) begin
      n_err++;
      $display("FAIL ignored_start: got %0d valids (first at %0d), expected 1 at 12", nv, first);
    end
    if (nv == 0) void'(sb.pop_front());
  endtask

  task automatic test_back_to_back;
    int nv, t1, t2;
    drive(12'h250, 1'b1, 1'b1);
    @(posedge clk); #1;
    nv = 0; t1 = 0; t2 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 13) start = 1'b0;
      if (valid === 1'b1) begin
        nv++;
        if (nv == 1) begin
          t1 = c;
          check_out("b2b_first");
          drive(12'h486, 1'b0, 1'b0);
        end else if (nv == 2) begin
          t2 = c;
          check_out("b2b_second");
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (nv != 2 || t1 != 12 || t2 != 25) begin
      n_err++;
      $display("FAIL b2b_timing: got %0d valids at %0d/%0d, expected 2 at 12/25", nv, t1, t2);
    end
    while (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset_mid;
    int nv;
    bcd_in = 12'h321; neg = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== 10'd0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b valid=%b result=%0d err=%b, expected all 0",
               busy, valid, result, err);
    end
    #1;
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv != 0) begin
      n_err++;
      $display("FAIL reset_mid_novalid: got %0d valids, expected 0", nv);
    end
    run_one(12'h042, 1'b0, 1'b0, "after_reset_042");
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_digit_err;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
